// File: rtl/countdown_pkg.sv
// Shared types and constants for the loadable countdown timer.
package countdown_pkg;

  localparam int unsigned COUNTDOWN_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_m.sv
// Loadable down-counter with a single-cycle expiry pulse and a sticky done level.
// Periodic reload at terminal count is built only when COUNTDOWN_AUTORELOAD_EN is defined.
module countdown_timer_m
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTDOWN_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload;

  // busy and done are flopped alongside state so every output comes straight from a register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count_out <= '0;
      reload    <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
      done      <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            state <= IDLE;
          end else if (load) begin
            count_out <= load_value;
            reload    <= load_value;
          end else if (start) begin
            if (count_out != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
              expired <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (load) begin
            count_out <= load_value;
            reload    <= load_value;
            if (load_value == '0) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              expired <= 1'b1;
            end
          end else if (enable) begin
            if (count_out > ONE) begin
              count_out <= count_out - ONE;
            end else begin
              expired <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              // Periodic mode: restart the interval unless there is nothing to reload.
              count_out <= reload;
              if (reload == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
`else
              count_out <= '0;
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end

        DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (load) begin
            count_out <= load_value;
            reload    <= load_value;
            state     <= IDLE;
            done      <= 1'b0;
          end else if (start) begin
            count_out <= reload;
            if (reload != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              expired <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          count_out <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_m.sv
// Scoreboard bench for countdown_timer_m: a behavioural model predicts each cycle's outputs.
module tb_countdown_timer_m;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         enable;
  logic         abort;
  logic [W-1:0] count_out;
  logic         busy;
  logic         expired;
  logic         done;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         exp;
    logic         done;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 run, 2 done.
  int           m_st;
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_rel;

  countdown_timer_m #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .enable     (enable),
    .abort      (abort),
    .count_out  (count_out),
    .busy       (busy),
    .expired    (expired),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_cnt = '0;
    m_rel = '0;
  endtask

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic st,
                      input logic en, input logic ab);
    logic e;
    exp_t x;
    exp_t o;
    e          = 1'b0;
    load       = ld;
    load_value = lv;
    start      = st;
    enable     = en;
    abort      = ab;
    if (ab) begin
      m_st = 0;
    end else if (ld) begin
      m_cnt = lv;
      m_rel = lv;
      if (m_st == 2) m_st = 0;
      else if (m_st == 1 && lv == 0) begin
        m_st = 2;
        e    = 1'b1;
      end
    end else if (st && m_st != 1) begin
      if (m_st == 2) m_cnt = m_rel;
      if (m_cnt == 0) begin
        m_st = 2;
        e    = 1'b1;
      end else begin
        m_st = 1;
      end
    end else if (en && m_st == 1) begin
      m_cnt = m_cnt - 1'b1;
      if (m_cnt == 0) begin
        e = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (m_rel != 0) m_cnt = m_rel;
        else m_st = 2;
`else
        m_st = 2;
`endif
      end
    end
    x.cnt  = m_cnt;
    x.busy = (m_st == 1);
    x.exp  = e;
    x.done = (m_st == 2);
    q.push_back(x);
    @(posedge clock);
    #1;
    o = q.pop_front();
    check("count_out", 32'(count_out), 32'(o.cnt));
    check("busy", 32'(busy), 32'(o.busy));
    check("expired", 32'(expired), 32'(o.exp));
    check("done", 32'(done), 32'(o.done));
  endtask

  initial begin
    int n;
    bit seen;
    reset_n    = 1'b0;
    load       = 1'b0;
    load_value = '0;
    start      = 1'b0;
    enable     = 1'b0;
    abort      = 1'b0;
    model_reset();
    #3;
    check("rst_count", 32'(count_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_expired", 32'(expired), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic countdown from 3 with enable held high.
    step(1, 4'd3, 0, 1, 0);
    step(0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 1);

    // Enable gaps.
    step(1, 4'd4, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 1);

    // Abort and resume.
    step(1, 4'd5, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 1);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 1);

    // Zero load, then load+start from DONE (load wins).
    step(1, 4'd0, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(1, 4'd2, 1, 0, 0);
    step(0, 4'd0, 0, 0, 0);

    // Abort beats enable at count 1.
    step(1, 4'd1, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 1);
    step(0, 4'd0, 0, 0, 0);

    // Load of zero while running forces DONE.
    step(1, 4'd5, 0, 0, 0);
    step(0, 4'd0, 1, 1, 0);
    step(0, 4'd0, 0, 1, 0);
    step(1, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 1);

    // Full-range interval: count enabled cycles to the first expiry.
    step(1, 4'd15, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step(0, 4'd0, 0, 1, 0);
      n++;
      seen = expired;
    end
    check("full_range_cycles", 32'(n), 15);
    // Restart from DONE via the reload value (or keep running in periodic mode).
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 1);

    // Short interval held enabled: one-shot stops, periodic mode repeats.
    step(1, 4'd2, 0, 0, 0);
    step(0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 1);
    step(0, 4'd0, 0, 0, 0);

    // Asynchronous reset while running at 6.
    step(1, 4'd8, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 0);
    check("pre_reset_count", 32'(count_out), 6);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", 32'(count_out), 0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    check("async_expired", 32'(expired), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
